// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// Merges ALU and load results into one register-file write port through a
// 4-entry FIFO. When both sources offer in the same cycle, a priority bit
// alternates between them. Writes to register 31 complete the handshake but
// are dropped, because that register reads as zero. One queued entry is issued
// per cycle unless the write port is held.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   alu_valid/rd/data       ALU result offer;  alu_ready accepts it
//   mem_valid/rd/data       load result offer; mem_ready accepts it
//   hold                    write port busy, stalls issue only
//   RegWrite/rd/write_data  registered register-file write
//   pending                 one bit per register with a queued write
//   level                   number of queued entries (0..4)
module writeback_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [7:0]  alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [7:0]  mem_data,
  output logic        mem_ready,
  input  logic        hold,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [7:0]  write_data,
  output logic [31:0] pending,
  output logic [2:0]  level
);

  logic [4:0] r_fifo_rd   [4];
  logic [7:0] r_fifo_data [4];
  logic [1:0] r_head;
  logic [1:0] r_tail;
  logic [2:0] r_count;
  logic       r_prio;

  logic       w_full;
  logic       w_alu_acc;
  logic       w_mem_acc;
  logic       w_push;
  logic       w_pop;
  logic       w_contend;
  logic [4:0] w_push_rd;
  logic [7:0] w_push_data;

  // Ready depends on count alone, so a full FIFO refuses input even in a
  // cycle where it also pops. A ready may be high with its valid low when
  // that source would win if it offered.
  assign w_full    = (r_count == 3'd4);
  assign alu_ready = !w_full && (!mem_valid || !r_prio);
  assign mem_ready = !w_full && (!alu_valid ||  r_prio);
  assign w_alu_acc = alu_valid && alu_ready;
  assign w_mem_acc = mem_valid && mem_ready;
  assign w_contend = alu_valid && mem_valid && !w_full;
  assign w_pop     = (r_count != 3'd0) && !hold;

  always_comb begin
    w_push_rd   = alu_rd;
    w_push_data = alu_data;
    w_push      = w_alu_acc && (alu_rd != 5'd31);
    if (w_mem_acc) begin
      w_push_rd   = mem_rd;
      w_push_data = mem_data;
      w_push      = (mem_rd != 5'd31);
    end
  end

  // FIFO storage needs no reset; only slots covered by count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_tail]   <= w_push_rd;
      r_fifo_data[r_tail] <= w_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      r_count    <= 3'd0;
      r_prio     <= 1'b0;
      RegWrite   <= 1'b0;
      rd         <= 5'd0;
      write_data <= 8'd0;
    end else begin
      if (w_contend) r_prio <= ~r_prio;
      if (w_push) r_tail <= r_tail + 2'd1;
      if (w_pop) begin
        r_head     <= r_head + 2'd1;
        RegWrite   <= 1'b1;
        rd         <= r_fifo_rd[r_head];
        write_data <= r_fifo_data[r_head];
      end else begin
        RegWrite   <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Only the live slots from head onward contribute. An entry already moved
  // into the output register is no longer in the FIFO.
  always_comb begin
    pending = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < r_count) pending[r_fifo_rd[r_head + 2'(i)]] = 1'b1;
    end
  end

  assign level = r_count;

endmodule
